// File: rtl/scemi_out_pipe_proxy_get.sv
// Output-pipe Get proxy: buffers producer words and end-of-message markers in a
// DEPTH-entry FIFO for a Get-style consumer. Optional SCEMI_PIPE_STATS_EN adds dequeue statistics.
module scemi_out_pipe_proxy_get #(
    parameter int    WIDTH          = 0,
    parameter int    DEPTH          = 4,
    parameter string paramFile      = "",
    parameter string transactorName = "",
    parameter string portName       = ""
) (
    input  logic                       CLK,
    input  logic                       RST_N,
    input  logic [WIDTH-1:0]           SRC_DATA,
    input  logic                       SRC_EOM,
    input  logic                       SRC_EN,
    output logic                       SRC_RDY,
    output logic [WIDTH-1:0]           DATA,
    output logic                       DATA_EOM,
    input  logic                       DATA_EN,
    output logic                       DATA_RDY,
    output logic [$clog2(DEPTH):0]     COUNT,
    output logic                       MSG_AVAIL
`ifdef SCEMI_PIPE_STATS_EN
    ,
    output logic [31:0]                WORD_CNT,
    output logic [15:0]                MSG_CNT
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    if (WIDTH < 1) begin : g_bad_width
        $error("scemi_out_pipe_proxy_get: WIDTH must be at least 1");
    end
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("scemi_out_pipe_proxy_get: DEPTH must be a power of two >= 2");
    end

    // Each entry is {eom, payload}; storage is deliberately left unreset.
    logic [WIDTH:0]    mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [CW-1:0]     count_q;
    logic [CW-1:0]     eom_cnt;
    logic [WIDTH:0]    head;
    logic              enq;
    logic              deq;
    logic              eom_inc;
    logic              eom_dec;

    assign head     = mem[rd_ptr];
    assign SRC_RDY  = ~RST_N & (count_q < FULL_CNT);
    assign DATA_RDY = (count_q != '0);

    // Strobes outside their ready window are dropped, so full never bypasses to a
    // same-cycle dequeue and empty never bypasses to a same-cycle enqueue.
    assign enq      = SRC_EN & SRC_RDY;
    assign deq      = DATA_EN & DATA_RDY;
    assign eom_inc  = enq & SRC_EOM;
    assign eom_dec  = deq & head[WIDTH];

    assign DATA      = DATA_RDY ? head[WIDTH-1:0] : '0;
    assign DATA_EOM  = DATA_RDY & head[WIDTH];
    assign COUNT     = count_q;
    assign MSG_AVAIL = (eom_cnt != '0);

    always_ff @(posedge CLK) begin
        if (enq) begin
            mem[wr_ptr] <= {SRC_EOM, SRC_DATA};
        end
    end

    always_ff @(posedge CLK or posedge RST_N) begin
        if (RST_N) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
            eom_cnt <= '0;
        end else begin
            if (enq) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (deq) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({enq, deq})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
            case ({eom_inc, eom_dec})
                2'b10:   eom_cnt <= eom_cnt + 1'b1;
                2'b01:   eom_cnt <= eom_cnt - 1'b1;
                default: eom_cnt <= eom_cnt;
            endcase
        end
    end

`ifdef SCEMI_PIPE_STATS_EN
    logic [31:0] word_cnt;
    logic [15:0] msg_cnt;

    // Free-running totals of consumed words and messages; wrap naturally.
    always_ff @(posedge CLK or posedge RST_N) begin
        if (RST_N) begin
            word_cnt <= '0;
            msg_cnt  <= '0;
        end else begin
            if (deq) begin
                word_cnt <= word_cnt + 32'd1;
            end
            if (eom_dec) begin
                msg_cnt <= msg_cnt + 16'd1;
            end
        end
    end

    assign WORD_CNT = word_cnt;
    assign MSG_CNT  = msg_cnt;
`endif

endmodule

// File: tb/tb_scemi_out_pipe_proxy_get.sv
// Scoreboard bench for scemi_out_pipe_proxy_get (WIDTH=8, DEPTH=4); stats checks
// compile in when SCEMI_PIPE_STATS_EN is defined.
module tb_scemi_out_pipe_proxy_get;

    localparam int W = 8;
    localparam int D = 4;

    logic         CLK;
    logic         RST_N;
    logic [W-1:0] SRC_DATA;
    logic         SRC_EOM;
    logic         SRC_EN;
    logic         SRC_RDY;
    logic [W-1:0] DATA;
    logic         DATA_EOM;
    logic         DATA_EN;
    logic         DATA_RDY;
    logic [2:0]   COUNT;
    logic         MSG_AVAIL;
`ifdef SCEMI_PIPE_STATS_EN
    logic [31:0]  WORD_CNT;
    logic [15:0]  MSG_CNT;
`endif

    int checks = 0;
    int errors = 0;

    // exp_q feeds the output monitor; mq is the driver's view of FIFO contents.
    logic [W:0] exp_q[$];
    logic [W:0] mq[$];

    scemi_out_pipe_proxy_get #(
        .WIDTH(W), .DEPTH(D), .paramFile(""), .transactorName("tb"), .portName("out")
    ) dut (
        .CLK(CLK), .RST_N(RST_N),
        .SRC_DATA(SRC_DATA), .SRC_EOM(SRC_EOM), .SRC_EN(SRC_EN), .SRC_RDY(SRC_RDY),
        .DATA(DATA), .DATA_EOM(DATA_EOM), .DATA_EN(DATA_EN), .DATA_RDY(DATA_RDY),
        .COUNT(COUNT), .MSG_AVAIL(MSG_AVAIL)
`ifdef SCEMI_PIPE_STATS_EN
        , .WORD_CNT(WORD_CNT), .MSG_CNT(MSG_CNT)
`endif
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every accepted dequeue must present the oldest expected word.
    always @(negedge CLK) begin
        if (!RST_N && DATA_EN && DATA_RDY) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL deq_unexpected: got 0x%0h expected no word", {DATA_EOM, DATA});
            end else begin
                chk("deq_word", {23'd0, DATA_EOM, DATA}, {23'd0, exp_q.pop_front()});
            end
        end
    end

    function automatic logic model_msg();
        foreach (mq[i]) if (mq[i][W]) return 1'b1;
        return 1'b0;
    endfunction

    task automatic check_state();
        logic [W:0] h;
        h = (mq.size() != 0) ? mq[0] : '0;
        chk("count", {29'd0, COUNT}, mq.size());
        chk("src_rdy", {31'd0, SRC_RDY}, {31'd0, mq.size() < D});
        chk("data_rdy", {31'd0, DATA_RDY}, {31'd0, mq.size() != 0});
        chk("head", {23'd0, DATA_EOM, DATA}, {23'd0, h});
        chk("msg_avail", {31'd0, MSG_AVAIL}, {31'd0, model_msg()});
    endtask

    // One clock of stimulus; called at posedge+1, returns at the next posedge+1.
    task automatic cycle(input logic en, input logic eom, input logic [W-1:0] d, input logic take);
        logic enq_ok;
        logic deq_ok;
        SRC_EN   = en;
        SRC_EOM  = eom;
        SRC_DATA = d;
        DATA_EN  = take;
        enq_ok = en && (mq.size() < D);
        deq_ok = take && (mq.size() != 0);
        if (enq_ok) exp_q.push_back({eom, d});
        @(posedge CLK);
        if (deq_ok) void'(mq.pop_front());
        if (enq_ok) mq.push_back({eom, d});
        #1;
        SRC_EN  = 1'b0;
        DATA_EN = 1'b0;
        check_state();
    endtask

    task automatic do_reset();
        SRC_EN = 1'b0;
        DATA_EN = 1'b0;
        RST_N = 1'b1;
        exp_q.delete();
        mq.delete();
        repeat (2) @(posedge CLK);
        #1;
        chk("rst_src_rdy", {31'd0, SRC_RDY}, 32'd0);
        RST_N = 1'b0;
    endtask

    initial begin
        SRC_EN = 1'b0; SRC_EOM = 1'b0; SRC_DATA = '0; DATA_EN = 1'b0;
        do_reset();
        #1;
        chk("idle_src_rdy", {31'd0, SRC_RDY}, 32'd1);
        chk("idle_data_rdy", {31'd0, DATA_RDY}, 32'd0);
        chk("idle_data", {24'd0, DATA}, 32'd0);
        chk("idle_count", {29'd0, COUNT}, 32'd0);
        chk("idle_msg", {31'd0, MSG_AVAIL}, 32'd0);
        @(posedge CLK); #1;

        // Fill with one message, then drain it.
        cycle(1'b1, 1'b0, 8'h11, 1'b0);
        cycle(1'b1, 1'b0, 8'h22, 1'b0);
        cycle(1'b1, 1'b0, 8'h33, 1'b0);
        chk("pre_eom_msg", {31'd0, MSG_AVAIL}, 32'd0);
        cycle(1'b1, 1'b1, 8'h44, 1'b0);
        chk("full_count", {29'd0, COUNT}, 32'd4);
        chk("full_src_rdy", {31'd0, SRC_RDY}, 32'd0);
        chk("full_msg", {31'd0, MSG_AVAIL}, 32'd1);
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 8'h00, 1'b1);
        chk("drain_count", {29'd0, COUNT}, 32'd0);
        chk("drain_msg", {31'd0, MSG_AVAIL}, 32'd0);

        // Steady streaming at occupancy 2, wrapping the pointers several times.
        cycle(1'b1, 1'b0, 8'hA0, 1'b0);
        cycle(1'b1, 1'b0, 8'hA1, 1'b0);
        for (int i = 0; i < 10; i++) begin
            cycle(1'b1, (i == 9), 8'hA2 + 8'(i), 1'b1);
            chk("stream_count", {29'd0, COUNT}, 32'd2);
        end
        cycle(1'b0, 1'b0, 8'h00, 1'b1);
        cycle(1'b0, 1'b0, 8'h00, 1'b1);

        // Full with simultaneous strobes: only the dequeue takes effect.
        for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 8'hC0 + 8'(i), 1'b0);
        cycle(1'b1, 1'b1, 8'h99, 1'b1);
        chk("full_bypass_count", {29'd0, COUNT}, 32'd3);
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 8'h00, 1'b1);
        chk("no_bypass_stored", {29'd0, COUNT}, 32'd0);

        // Illegal dequeue on empty must not move the read pointer.
        cycle(1'b0, 1'b0, 8'h00, 1'b1);
        chk("illegal_deq_count", {29'd0, COUNT}, 32'd0);
        cycle(1'b1, 1'b1, 8'h5A, 1'b0);
        chk("after_illegal_head", {24'd0, DATA}, 32'h5A);
        cycle(1'b0, 1'b0, 8'h00, 1'b1);

        // Asynchronous reset with three words buffered.
        cycle(1'b1, 1'b0, 8'h61, 1'b0);
        cycle(1'b1, 1'b1, 8'h62, 1'b0);
        cycle(1'b1, 1'b0, 8'h63, 1'b0);
        #2 RST_N = 1'b1;
        #1;
        chk("async_data_rdy", {31'd0, DATA_RDY}, 32'd0);
        chk("async_count", {29'd0, COUNT}, 32'd0);
        chk("async_msg", {31'd0, MSG_AVAIL}, 32'd0);
        chk("async_data", {24'd0, DATA}, 32'd0);
        exp_q.delete();
        mq.delete();
        @(posedge CLK); @(posedge CLK); #1;
        RST_N = 1'b0;
        cycle(1'b0, 1'b0, 8'h00, 1'b0);
        cycle(1'b1, 1'b0, 8'h71, 1'b0);
        cycle(1'b0, 1'b0, 8'h00, 1'b1);

`ifdef SCEMI_PIPE_STATS_EN
        do_reset();
        #1;
        chk("stats_rst_words", WORD_CNT, 32'd0);
        chk("stats_rst_msgs", {16'd0, MSG_CNT}, 32'd0);
        cycle(1'b1, 1'b0, 8'h01, 1'b0);
        cycle(1'b1, 1'b0, 8'h02, 1'b0);
        cycle(1'b1, 1'b1, 8'h03, 1'b1);
        cycle(1'b1, 1'b0, 8'h04, 1'b1);
        cycle(1'b1, 1'b1, 8'h05, 1'b1);
        cycle(1'b0, 1'b0, 8'h00, 1'b1);
        cycle(1'b0, 1'b0, 8'h00, 1'b1);
        chk("stats_words", WORD_CNT, 32'd5);
        chk("stats_msgs", {16'd0, MSG_CNT}, 32'd2);
`endif

        repeat (2) @(posedge CLK);
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL leftover_expected: got %0d words outstanding expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
